alu_issue_stage: RTL and testbench

- Sequential operand-issue stage directly upstream of the 32-bit ALU.
- Accepts one operation (A, B, 3-bit command) per valid/ready handshake and holds it stable on the ALU inputs for a programmable settle window, sized for the ALU's gate-delay critical path (the 32-input zero NOR).
- Captures result and flags into an output register and presents them downstream with valid/ready backpressure.

---
 rtl/alu_issue_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue stage in front of the 32-bit ALU.
// Takes one op per in_valid/in_ready handshake, holds it on the ALU inputs
// for SETTLE_CYCLES edges, then captures result/flags for a downstream
// valid/ready consumer.
// Optional behavioural self-check of the ALU: define ALU_ISSUE_CHECK_EN.
//
// state  | meaning
// IDLE   | nothing in flight, ready to accept an op
// SETTLE | ALU inputs held stable, settle counter running
// HOLD   | result captured, waiting for out_ready
module alu_issue_stage #(
  parameter int SETTLE_CYCLES = 4,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_cmd,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [2:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [2:0]       out_cmd,
  output logic             busy,
  output logic             mismatch
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       accept;
  logic       capture;
  logic       retire;
  logic       arith_cmd;

  assign accept    = in_valid & in_ready;
  assign capture   = (state == SETTLE) && (cnt == 8'd0);
  assign retire    = (state == HOLD) && out_ready;
  assign busy      = (state != IDLE);
  // Carry and overflow only carry meaning for the adder commands.
  assign arith_cmd = (alu_command == CMD_ADD) || (alu_command == CMD_SUB);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and in_ready; in_ready must not look at in_valid
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == 8'd0) state_nxt = HOLD;
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU input registers and settle counter; ALU inputs move only on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= 8'd0;
      alu_operandA <= '0;
      alu_operandB <= '0;
      alu_command  <= 3'd0;
    end else begin
      if (accept) begin
        alu_operandA <= in_a;
        alu_operandB <= in_b;
        alu_command  <= in_cmd;
        cnt          <= CNT_INIT;
      end else if ((state == SETTLE) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  // Output register: capture at end of settle, drop valid on retire
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_carryout <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_cmd      <= 3'd0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_result   <= alu_result;
      out_zero     <= alu_zero;
      out_cmd      <= alu_command;
      out_carryout <= arith_cmd ? alu_carryout : 1'b0;
      out_overflow <= arith_cmd ? alu_overflow : 1'b0;
    end else if (retire) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_CHECK_EN
  logic [WIDTH-1:0] exp_result;
  logic             exp_zero;

  // Reference ALU evaluated on the held operands
  always_comb begin
    exp_result = '0;
    case (alu_command)
      CMD_ADD:  exp_result = alu_operandA + alu_operandB;
      CMD_SUB:  exp_result = alu_operandA - alu_operandB;
      CMD_XOR:  exp_result = alu_operandA ^ alu_operandB;
      CMD_SLT:  exp_result = {{(WIDTH-1){1'b0}},
                              ($signed(alu_operandA) < $signed(alu_operandB))};
      CMD_AND:  exp_result = alu_operandA & alu_operandB;
      CMD_NAND: exp_result = ~(alu_operandA & alu_operandB);
      CMD_NOR:  exp_result = ~(alu_operandA | alu_operandB);
      CMD_OR:   exp_result = alu_operandA | alu_operandB;
      default:  exp_result = '0;
    endcase
    exp_zero = (exp_result == '0);
  end

  // Sticky mismatch flag, compared at the capture edge only
  always_ff @(posedge clk) begin
    if (reset)
      mismatch <= 1'b0;
    else if (capture && ((exp_result != alu_result) || (exp_zero != alu_zero)))
      mismatch <= 1'b1;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: transaction-level model checked
// every cycle plus literal expectations for the directed scenarios.
module tb_alu_issue_stage;

  localparam int S = 4;
`ifdef ALU_ISSUE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_cmd = 3'd0;
  logic [31:0] alu_operandA, alu_operandB;
  logic [2:0]  alu_command;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_carryout, out_zero, out_overflow;
  logic [2:0]  out_cmd;
  logic        busy, mismatch;

  logic        force_res_en = 1'b0;
  logic [31:0] force_res = '0;
  logic        force_flags = 1'b0;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  alu_issue_stage #(.SETTLE_CYCLES(S), .WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_command(alu_command),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carryout(out_carryout), .out_zero(out_zero),
    .out_overflow(out_overflow), .out_cmd(out_cmd),
    .busy(busy), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // {carry, overflow, result} of a correct 32-bit ALU
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] cmd);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (cmd)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {c, v, r};
  endfunction

  // Bench-side ALU, with fault injection knobs
  logic [33:0] drv_v;
  always_comb begin
    drv_v        = alu_ref(alu_operandA, alu_operandB, alu_command);
    alu_result   = force_res_en ? force_res : drv_v[31:0];
    alu_carryout = (alu_command < 3'd2) ? drv_v[33] : force_flags;
    alu_overflow = (alu_command < 3'd2) ? drv_v[32] : force_flags;
    alu_zero     = (alu_result == 32'd0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: what the stage must present, from the behaviour rules
  logic        m_active, m_valid, m_mis;
  int          m_wait;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_cmd, m_ocmd;
  logic        m_c, m_z, m_o;

  always @(posedge clk) begin
    logic        rdy, acc;
    logic [33:0] rv;
    logic [31:0] dres;
    if (reset) begin
      m_active = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_wait = 0;
      m_a = '0; m_b = '0; m_cmd = '0;
      m_res = '0; m_ocmd = '0; m_c = 1'b0; m_z = 1'b0; m_o = 1'b0;
    end else begin
      rdy = !m_active || (m_valid && out_ready);
      acc = in_valid && rdy;
      if (m_active && !m_valid) begin
        if (m_wait == 0) begin
          rv    = alu_ref(m_a, m_b, m_cmd);
          dres  = force_res_en ? force_res : rv[31:0];
          m_res = dres;
          m_z   = (dres == 32'd0);
          m_ocmd = m_cmd;
          m_c   = (m_cmd < 3'd2) ? rv[33] : 1'b0;
          m_o   = (m_cmd < 3'd2) ? rv[32] : 1'b0;
          if (CHK && (dres != rv[31:0])) m_mis = 1'b1;
          m_valid = 1'b1;
        end else begin
          m_wait--;
        end
      end else if (m_valid && out_ready) begin
        m_valid  = 1'b0;
        m_active = 1'b0;
      end
      if (acc) begin
        m_a = in_a; m_b = in_b; m_cmd = in_cmd;
        m_wait = S - 1;
        m_active = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("in_ready", 64'(in_ready), 64'(!m_active || (m_valid && out_ready)));
      check("busy", 64'(busy), 64'(m_active));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("mismatch", 64'(mismatch), 64'(m_mis));
      check("alu_operandA", 64'(alu_operandA), 64'(m_a));
      check("alu_operandB", 64'(alu_operandB), 64'(m_b));
      check("alu_command", 64'(alu_command), 64'(m_cmd));
      check("out_result", 64'(out_result), 64'(m_res));
      check("out_flags", 64'({out_carryout, out_zero, out_overflow}), 64'({m_c, m_z, m_o}));
      check("out_cmd", 64'(out_cmd), 64'(m_ocmd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for out_valid; returns edges elapsed since the accept edge
  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] cmd, input logic [31:0] er,
                        input logic ec, input logic ez, input logic eo);
    int n;
    tick();
    in_a = a; in_b = b; in_cmd = cmd; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    check({name, "_latency"}, 64'(n), 64'(S));
    check({name, "_result"}, 64'(out_result), 64'(er));
    check({name, "_flags"}, 64'({out_carryout, out_zero, out_overflow}), 64'({ec, ez, eo}));
    check({name, "_cmd"}, 64'(out_cmd), 64'(cmd));
    @(negedge clk);
    check({name, "_valid_1cyc"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_a", 64'(alu_operandA), 64'd0);

    run_op("add", 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    run_op("sub", 32'h8000_0000, 32'h0000_0001, 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    run_op("slt", 32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    force_flags = 1'b1;
    run_op("xor_mask", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0);
    run_op("and", 32'hF0F0_1234, 32'h0FF0_FFFF, 3'd4, 32'h00F0_1234, 1'b0, 1'b0, 1'b0);
    force_flags = 1'b0;

    // Backpressure: result held while out_ready=0, NOR op waiting upstream
    tick();
    in_a = 32'd5; in_b = 32'd3; in_cmd = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_a = 32'h0; in_b = 32'h0; in_cmd = 3'd6;
    wait_valid(n);
    check("bp_latency", 64'(n), 64'(S));
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_result", 64'(out_result), 64'd8);
      check("bp_alu_a", 64'(alu_operandA), 64'd5);
      check("bp_alu_cmd", 64'(alu_command), 64'd0);
    end
    tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    check("bp_second_latency", 64'(n), 64'(S));
    check("bp_nor_result", 64'(out_result), 64'hFFFF_FFFF);
    check("bp_nor_cmd", 64'(out_cmd), 64'd6);
    @(negedge clk);

    // Reset two cycles into SETTLE
    tick();
    in_a = 32'd7; in_b = 32'd9; in_cmd = 3'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_alu_a", 64'(alu_operandA), 64'd0);
    check("mid_rst_alu_cmd", 64'(alu_command), 64'd0);
    repeat (8) begin
      @(negedge clk);
      check("mid_rst_no_valid", 64'(out_valid), 64'd0);
    end

    // Faulty ALU result: sticky mismatch only when the checker is built in
    force_res_en = 1'b1; force_res = 32'h1;
    run_op("bad_add", 32'd2, 32'd2, 3'd0, 32'h1, 1'b0, 1'b0, 1'b0);
    check("mismatch_set", 64'(mismatch), 64'(CHK));
    force_res_en = 1'b0;
    run_op("good_add", 32'd1, 32'd1, 3'd0, 32'h2, 1'b0, 1'b0, 1'b0);
    check("mismatch_sticky", 64'(mismatch), 64'(CHK));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mismatch_cleared", 64'(mismatch), 64'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
